endme_core_mc: RTL

- Parametrised multi-cycle successor to the single-cycle EnDMe accumulator datapath.
- Keeps the 9-bit accumulator ISA and adds a FETCH/EXEC/MEM/HALT state machine.
- Instruction and data memories sit outside the core, each behind a req/valid (or req/ack) handshake, so wait-stated memories are tolerated.
- Adds a carry flag, a HALT instruction and a parametrised data/PC width; sits as the CPU core under the top level.

---
 rtl/endme_pkg.sv | 34 +++
 rtl/endme_alu.sv | 55 +++++
 rtl/endme_core_mc.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/endme_pkg.sv
// Shared EnDMe definitions: instruction field layout, opcode and FSM state encodings.
package endme_pkg;

  localparam int INSTR_W   = 9;
  localparam int REG_SEL_W = 4;
  localparam int TYP_BIT   = 8;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_MOVA = 4'h1,
    OP_MOVR = 4'h2,
    OP_ADD  = 4'h3,
    OP_SUB  = 4'h4,
    OP_AND  = 4'h5,
    OP_OR   = 4'h6,
    OP_XOR  = 4'h7,
    OP_SHL  = 4'h8,
    OP_SHR  = 4'h9,
    OP_LD   = 4'hA,
    OP_ST   = 4'hB,
    OP_BZ   = 4'hC,
    OP_JMP  = 4'hD,
    OP_RSVD = 4'hE,
    OP_HALT = 4'hF
  } opcode_e;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_MEM   = 2'd2,
    ST_HALT  = 2'd3
  } state_e;

endpackage

// File: rtl/endme_alu.sv
// Combinational accumulator ALU; result defaults to acc for ops that leave it untouched.
module endme_alu
  import endme_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] acc_i,
  input  logic [DATA_W-1:0] opnd_i,
  input  opcode_e           op_i,
  output logic [DATA_W-1:0] res_o,
  output logic              carry_o,
  output logic              carry_upd_o
);

  logic [DATA_W:0] sum;
  logic [DATA_W:0] diff;

  // The extra top bit of the difference is the unsigned borrow.
  assign sum  = {1'b0, acc_i} + {1'b0, opnd_i};
  assign diff = {1'b0, acc_i} - {1'b0, opnd_i};

  always_comb begin
    res_o       = acc_i;
    carry_o     = 1'b0;
    carry_upd_o = 1'b0;
    case (op_i)
      OP_MOVA: res_o = opnd_i;
      OP_ADD: begin
        res_o       = sum[DATA_W-1:0];
        carry_o     = sum[DATA_W];
        carry_upd_o = 1'b1;
      end
      OP_SUB: begin
        res_o       = diff[DATA_W-1:0];
        carry_o     = diff[DATA_W];
        carry_upd_o = 1'b1;
      end
      OP_AND: res_o = acc_i & opnd_i;
      OP_OR:  res_o = acc_i | opnd_i;
      OP_XOR: res_o = acc_i ^ opnd_i;
      OP_SHL: begin
        res_o       = {acc_i[DATA_W-2:0], 1'b0};
        carry_o     = acc_i[DATA_W-1];
        carry_upd_o = 1'b1;
      end
      OP_SHR: begin
        res_o       = {1'b0, acc_i[DATA_W-1:1]};
        carry_o     = acc_i[0];
        carry_upd_o = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/endme_core_mc.sv
// Multi-cycle EnDMe accumulator core (FETCH/EXEC/MEM/HALT) with handshaked imem/dmem.
// Defining ENDME_PERF_CNT_EN adds the retired_cnt instruction counter output.
module endme_core_mc
  import endme_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int PC_W   = 16,
  parameter int NREGS  = 16
) (
  input  logic               CLK,
  input  logic               RESET,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_valid,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [DATA_W-1:0]  dmem_addr,
  output logic [DATA_W-1:0]  dmem_wdata,
  input  logic [DATA_W-1:0]  dmem_rdata,
  input  logic               dmem_ack,
  output logic [DATA_W-1:0]  acc_out,
  output logic               carry_out,
  output logic               halted
`ifdef ENDME_PERF_CNT_EN
  ,
  output logic [31:0]        retired_cnt
`endif
);

  if (NREGS != 16) begin : g_nregs_chk
    $error("endme_core_mc: NREGS must be 16 to match the 4-bit register field");
  end
  if (DATA_W < 8) begin : g_width_chk
    $error("endme_core_mc: DATA_W must be at least 8");
  end

  state_e              state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic                carry_q, carry_d;
  logic [INSTR_W-1:0]  ir_q, ir_d;
  logic [DATA_W-1:0]   regs_q [NREGS];
  logic [DATA_W-1:0]   regs_d [NREGS];
  logic                imem_req_q, imem_req_d;
  logic                dmem_req_q, dmem_req_d;
  logic                dmem_we_q, dmem_we_d;
  logic [DATA_W-1:0]   dmem_addr_q, dmem_addr_d;
  logic [DATA_W-1:0]   dmem_wdata_q, dmem_wdata_d;
  logic                halted_q, halted_d;

  opcode_e               op;
  logic [REG_SEL_W-1:0]  rsel;
  logic [DATA_W-1:0]     opnd;
  logic [PC_W-1:0]       tgt;
  logic [DATA_W-1:0]     alu_res;
  logic                  alu_carry;
  logic                  alu_carry_upd;

  assign op   = opcode_e'(ir_q[7:4]);
  assign rsel = ir_q[REG_SEL_W-1:0];
  assign opnd = regs_q[rsel];
  assign tgt  = PC_W'(opnd);

  endme_alu #(.DATA_W(DATA_W)) u_alu (
    .acc_i       (acc_q),
    .opnd_i      (opnd),
    .op_i        (op),
    .res_o       (alu_res),
    .carry_o     (alu_carry),
    .carry_upd_o (alu_carry_upd)
  );

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    acc_d        = acc_q;
    carry_d      = carry_q;
    ir_d         = ir_q;
    regs_d       = regs_q;
    imem_req_d   = imem_req_q;
    dmem_req_d   = dmem_req_q;
    dmem_we_d    = dmem_we_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_wdata_d = dmem_wdata_q;
    halted_d     = halted_q;
    case (state_q)
      // The first FETCH after reset only raises the request; valid counts once it is up.
      ST_FETCH: begin
        imem_req_d = 1'b1;
        if (imem_req_q && imem_valid) begin
          ir_d       = imem_rdata;
          imem_req_d = 1'b0;
          state_d    = ST_EXEC;
        end
      end
      ST_EXEC: begin
        pc_d       = pc_q + PC_W'(1);
        state_d    = ST_FETCH;
        imem_req_d = 1'b1;
        if (ir_q[TYP_BIT]) begin
          acc_d = DATA_W'(ir_q[7:0]);
        end else begin
          acc_d = alu_res;
          if (alu_carry_upd) carry_d = alu_carry;
          case (op)
            OP_MOVR: regs_d[rsel] = acc_q;
            OP_BZ:   if (acc_q == '0) pc_d = tgt;
            OP_JMP:  pc_d = tgt;
            OP_LD, OP_ST: begin
              state_d      = ST_MEM;
              imem_req_d   = 1'b0;
              dmem_req_d   = 1'b1;
              dmem_we_d    = (op == OP_ST);
              dmem_addr_d  = opnd;
              dmem_wdata_d = acc_q;
            end
            OP_HALT: begin
              state_d    = ST_HALT;
              imem_req_d = 1'b0;
              halted_d   = 1'b1;
            end
            default: ;
          endcase
        end
      end
      ST_MEM: begin
        if (dmem_ack) begin
          if (!dmem_we_q) acc_d = dmem_rdata;
          dmem_req_d = 1'b0;
          dmem_we_d  = 1'b0;
          imem_req_d = 1'b1;
          state_d    = ST_FETCH;
        end
      end
      ST_HALT: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q      <= ST_FETCH;
      pc_q         <= '0;
      acc_q        <= '0;
      carry_q      <= 1'b0;
      ir_q         <= '0;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      imem_req_q   <= 1'b0;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= '0;
      halted_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      acc_q        <= acc_d;
      carry_q      <= carry_d;
      ir_q         <= ir_d;
      regs_q       <= regs_d;
      imem_req_q   <= imem_req_d;
      dmem_req_q   <= dmem_req_d;
      dmem_we_q    <= dmem_we_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_wdata_q <= dmem_wdata_d;
      halted_q     <= halted_d;
    end
  end

  assign imem_req   = imem_req_q;
  assign imem_addr  = pc_q;
  assign dmem_req   = dmem_req_q;
  assign dmem_we    = dmem_we_q;
  assign dmem_addr  = dmem_addr_q;
  assign dmem_wdata = dmem_wdata_q;
  assign acc_out    = acc_q;
  assign carry_out  = carry_q;
  assign halted     = halted_q;

`ifdef ENDME_PERF_CNT_EN
  logic [31:0] retired_q, retired_d;
  logic        is_mem;

  // Memory ops retire on their ack; everything else, HALT included, on leaving EXEC.
  always_comb begin
    is_mem    = !ir_q[TYP_BIT] && (op == OP_LD || op == OP_ST);
    retired_d = retired_q;
    if ((state_q == ST_EXEC && !is_mem) || (state_q == ST_MEM && dmem_ack))
      retired_d = retired_q + 32'd1;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) retired_q <= '0;
    else       retired_q <= retired_d;
  end

  assign retired_cnt = retired_q;
`endif

endmodule
